ula_seq: RTL and testbench

- Parametrised, multi-cycle successor to the core's single-cycle ALU.
- Add, sub, and, or, xor and set-less-than complete in one cycle.
- Signed multiply (shift-add) and signed divide (restoring) run iteratively over WIDTH cycles, so no wide combinational multiplier or divider is built.
- Sits in the execute stage and uses a start/busy/done handshake so the core controller can stall while an operation is in flight.

---
 rtl/ula_seq.sv | 119 +++++++++++
 tb/tb_ula_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// ula_seq: multi-cycle ALU; single-cycle add/sub/logic/slt, iterative signed mul/div; ports clk, rst, start, inA, inB, func -> busy, done, result, overflow, zero, div_by_zero
module ula_seq #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [3:0]       func,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam int M = WIDTH - 1;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] p, prod;
  logic [WIDTH-1:0] mc, abs_a, abs_b, add_r, sub_r, quot, nres, diff;
  logic [WIDTH:0] msum, shl;
  logic neg, op_div, load, nov, ndbz, ge;
  assign busy  = state != IDLE;
  assign abs_a = inA[M] ? -inA : inA;
  assign abs_b = inB[M] ? -inB : inB;
  assign add_r = inA + inB;
  assign sub_r = inA - inB;
  // shift-add step: conditionally add multiplicand into the high half, shift right
  assign msum  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mc} : '0);
  // restoring step: partial remainder in the high half, dividend/quotient in the low half
  assign shl   = {p[2*WIDTH-1:WIDTH], p[M]};
  assign ge    = shl >= {1'b0, mc};
  assign diff  = shl[WIDTH-1:0] - mc;
  assign prod  = neg ? -p : p;
  assign quot  = neg ? -p[WIDTH-1:0] : p[WIDTH-1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    load = 1'b0;
    nres = '0;
    nov = 1'b0;
    ndbz = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (func == 4'd2 || (func == 4'd3 && inB != '0)) state_n = ITER;
        else begin
          load = 1'b1;
          case (func)
            4'd0: begin
              nres = add_r;
              nov = (inA[M] == inB[M]) && (add_r[M] != inA[M]);
            end
            4'd1: begin
              nres = sub_r;
              nov = (inA[M] != inB[M]) && (sub_r[M] != inA[M]);
            end
            4'd3: begin
              nov = 1'b1;
              ndbz = 1'b1;
            end
            4'd4: nres = inA & inB;
            4'd5: nres = inA | inB;
            4'd6: nres = inA ^ inB;
            4'd7: nres = {{(WIDTH-1){1'b0}}, $signed(inA) < $signed(inB)};
            default: nres = '0;
          endcase
        end
      end
      ITER: state_n = cnt == LAST ? FIX : ITER;
      FIX: begin
        state_n = IDLE;
        load = 1'b1;
        nres = op_div ? quot : prod[WIDTH-1:0];
        // div can only overflow as a positive quotient of 2^(WIDTH-1) (MIN / -1)
        nov = op_div ? (!neg && p[M]) : !(&prod[2*WIDTH-1:M] || ~|prod[2*WIDTH-1:M]);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      p <= '0;
      mc <= '0;
      neg <= 1'b0;
      op_div <= 1'b0;
      done <= 1'b0;
      result <= '0;
      overflow <= 1'b0;
      zero <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= load;
      if (load) begin
        result <= nres;
        overflow <= nov;
        zero <= nres == '0;
        div_by_zero <= ndbz;
      end
      if (state == IDLE && state_n == ITER) begin
        cnt <= '0;
        op_div <= func[0];
        neg <= inA[M] ^ inB[M];
        mc <= abs_b;
        p <= {{WIDTH{1'b0}}, abs_a};
      end else if (state == ITER) begin
        cnt <= cnt + 1'b1;
        p <= op_div ? (ge ? {diff, p[M-1:0], 1'b1} : {shl[WIDTH-1:0], p[M-1:0], 1'b0})
                    : {msum, p[WIDTH-1:1]};
      end
    end
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: self-checking bench for ula_seq against a 64-bit arithmetic reference model
module tb_ula_seq;
  logic clk = 0, rst = 1, start = 0;
  logic [31:0] inA = 0, inB = 0, result;
  logic [3:0] func = 0;
  logic busy, done, overflow, zero, div_by_zero;
  int checks = 0, errors = 0;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  ula_seq #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .start(start), .inA(inA), .inB(inB), .func(func),
    .busy(busy), .done(done), .result(result), .overflow(overflow), .zero(zero), .div_by_zero(div_by_zero));

  always #5 clk = ~clk;

  function automatic void model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ov, output logic dbz, output int lat);
    longint sa, sb, full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    full = 0; ov = 0; dbz = 0; lat = 1;
    case (f)
      4'd0: full = sa + sb;
      4'd1: full = sa - sb;
      4'd2: begin full = sa * sb; lat = 34; end
      4'd3: if (sb == 0) begin ov = 1; dbz = 1; end else begin full = sa / sb; lat = 34; end
      4'd4: full = longint'(a & b);
      4'd5: full = longint'(a | b);
      4'd6: full = longint'(a ^ b);
      4'd7: full = (sa < sb) ? 1 : 0;
      default: full = 0;
    endcase
    if (f <= 4'd3 && (full > MAXS || full < MINS)) ov = 1;
    r = full[31:0];
  endfunction

  task automatic run_op(input string name, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic eov, edbz;
    int lat, n, bcnt;
    model(f, a, b, er, eov, edbz, lat);
    @(negedge clk);
    start = 1; func = f; inA = a; inB = b;
    @(posedge clk);
    @(negedge clk);
    start = 0; func = 4'($urandom); inA = $urandom; inB = $urandom;
    n = 1; bcnt = 0;
    while (!done && n < 100) begin
      bcnt += busy;
      @(negedge clk);
      n++;
    end
    bcnt += busy;
    checks++;
    if (n !== lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, n, lat); end
    checks++;
    if (bcnt !== lat - 1) begin errors++; $display("FAIL %s busy cycles: got %0d expected %0d", name, bcnt, lat - 1); end
    checks++;
    if ({result, overflow, zero, div_by_zero} !== {er, eov, er == 0, edbz}) begin
      errors++;
      $display("FAIL %s f=%h a=%h b=%h: got r=%h ov=%b z=%b dbz=%b expected r=%h ov=%b z=%b dbz=%b",
               name, f, a, b, result, overflow, zero, div_by_zero, er, eov, er == 0, edbz);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== er) begin errors++; $display("FAIL %s done width/hold: done=%b r=%h expected done=0 r=%h", name, done, result, er); end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({busy, done, result, overflow, zero, div_by_zero} !== 37'd0) begin
      errors++; $display("FAIL reset state: busy=%b done=%b r=%h ov=%b z=%b dbz=%b expected all 0", busy, done, result, overflow, zero, div_by_zero);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL post-reset idle: busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_directed;
    run_op("add_ovf", 4'd0, 32'h7FFFFFFF, 32'h00000001);
    run_op("sub_zero", 4'd1, 32'd5, 32'd5);
    run_op("mul_neg", 4'd2, -32'sd7, 32'd6);
    run_op("mul_ovf", 4'd2, 32'h00010000, 32'h00010000);
    run_op("div_neg", 4'd3, -32'sd7, 32'd2);
    run_op("div_min", 4'd3, 32'h80000000, 32'hFFFFFFFF);
    run_op("div_zero", 4'd3, 32'd9, 32'd0);
    run_op("mul_min", 4'd2, 32'h80000000, 32'd1);
    run_op("mul_min_neg", 4'd2, 32'h80000000, 32'hFFFFFFFF);
    run_op("div_min_pos", 4'd3, 32'h80000000, 32'd1);
    run_op("sub_ovf", 4'd1, 32'h80000000, 32'd1);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) b = $urandom_range(0, 20) - 10;
      if (i % 4 == 2) a = {{16{a[15]}}, a[15:0]};
      run_op("random", 4'($urandom_range(0, 15)), a, b);
    end
  endtask

  task automatic test_ignored_start;
    int n, dcnt, first;
    logic [31:0] r_at;
    @(negedge clk);
    start = 1; func = 4'd2; inA = -32'sd7; inB = 32'd6;
    @(posedge clk);
    n = 0; dcnt = 0; first = 0; r_at = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == 5 || c == 20);
      func = 4'd0; inA = 32'd1; inB = 32'd2;
      if (done) begin dcnt++; if (first == 0) begin first = c; r_at = result; end end
    end
    start = 0;
    checks++;
    if (dcnt !== 1 || first !== 34 || r_at !== 32'hFFFFFFD6) begin
      errors++; $display("FAIL ignored_start: dones=%0d at=%0d r=%h expected 1 at 34 r=ffffffd6", dcnt, first, r_at);
    end
  endtask

  task automatic test_reset_mid;
    int dcnt;
    @(negedge clk);
    start = 1; func = 4'd3; inA = 32'd1000; inB = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_div busy: got %b expected 1", busy); end
    #2 rst = 1;
    #1;
    checks++;
    if ({busy, done, result} !== 34'd0) begin errors++; $display("FAIL async reset: busy=%b done=%b r=%h expected 0 0 0", busy, done, result); end
    @(negedge clk);
    rst = 0;
    dcnt = 0;
    repeat (40) begin @(negedge clk); dcnt += done; end
    checks++;
    if (dcnt !== 0) begin errors++; $display("FAIL no done after reset: got %0d dones expected 0", dcnt); end
    run_op("add_after_rst", 4'd0, 32'd100, 32'hFFFFFFFF);
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_r[3];
    logic [3:0] fs[3];
    logic [31:0] as[3], bs[3];
    fs = '{4'd4, 4'd7, 4'd15};
    as = '{32'hF0F0F0F0, 32'hFFFFFFFF, 32'h12345678};
    bs = '{32'h0FF00FF0, 32'd1, 32'h9ABCDEF0};
    exp_r = '{32'h00F000F0, 32'd1, 32'd0};
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (done !== 1'b1 || result !== exp_r[i-1] || zero !== (exp_r[i-1] == 0)) begin
          errors++; $display("FAIL back_to_back %0d: done=%b r=%h z=%b expected done=1 r=%h z=%b", i - 1, done, result, zero, exp_r[i-1], exp_r[i-1] == 0);
        end
      end
      start = i < 3;
      if (i < 3) begin func = fs[i]; inA = as[i]; inB = bs[i]; end
      @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL back_to_back tail: done=%b expected 0", done); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_ignored_start;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
